mem_ctrl: RTL

- Single-port memory controller between the CPU pipeline and the byte-wide unified RAM.
- Serves instruction fetches from IF and data loads/stores from MEM.
- Serialises each 32/16/8-bit access into consecutive byte transfers, little-endian.
- MEM has priority over IF. Returns fetched instructions to IF and load data to MEM with a one-cycle valid pulse.

---
 rtl/mem_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//
// Single-port memory controller between the CPU pipeline and a byte-wide
// unified RAM. Serves instruction fetches (IF) and data loads/stores (MEM). A
// MEM request wins over an IF request. Every 8/16/32-bit access becomes a run
// of consecutive byte transfers, least significant byte first.
//
// Ports
//   clk_in        system clock, rising edge
//   rst_in        asynchronous active-high reset
//   IF_req_in     fetch request, held by IF until served
//   IF_addr_in    fetch byte address
//   MEM_req_in    data access request, held by MEM until served
//   MEM_we_in     1 = store, 0 = load
//   MEM_len_in    0 = byte, 1 = half, 2/3 = word
//   MEM_addr_in   data byte address
//   MEM_data_in   store data (low bytes used)
//   ram_data_in   RAM read byte, valid one cycle after its address
//   busy_out      controller occupied by an access
//   instE_out     one-cycle pulse, inst_out valid
//   inst_out      last fetched instruction
//   MEM_done_out  one-cycle pulse, MEM access complete
//   MEM_data_out  last load data, zero-extended
//   ram_addr_out  RAM byte address
//   ram_wr_out    write strobe for ram_data_out
//   ram_data_out  RAM write byte
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      IF_req_in,
    input  logic [31:0]               IF_addr_in,
    input  logic                      MEM_req_in,
    input  logic                      MEM_we_in,
    input  logic [1:0]                MEM_len_in,
    input  logic [31:0]               MEM_addr_in,
    input  logic [31:0]               MEM_data_in,
    input  logic [7:0]                ram_data_in,
    output logic                      busy_out,
    output logic                      instE_out,
    output logic [31:0]               inst_out,
    output logic                      MEM_done_out,
    output logic [31:0]               MEM_data_out,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_out,
    output logic                      ram_wr_out,
    output logic [7:0]                ram_data_out
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IF_RD  = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [31:0]               base_q;      // latched request address (IF compare)
    logic [RAM_ADDR_WIDTH-1:0] addr_q;      // address of the byte being driven
    logic [2:0]                cnt_q;       // cycles spent in the current access
    logic [2:0]                nbytes_q;    // access length in bytes: 1, 2 or 4
    logic                      is_mem_q;    // current/last access belongs to MEM
    logic [31:0]               wdata_q;     // store data, shifted out a byte at a time
    logic [31:0]               rdata_q;     // read bytes assembled so far
    logic [31:0]               inst_q;
    logic [31:0]               mdata_q;

    logic                      start_mem, start_if, if_abort, finish;
    logic [2:0]                mem_nbytes;
    logic [31:0]               start_addr;
    logic [31:0]               rdata_nx;

    always_comb begin
        mem_nbytes = (MEM_len_in == 2'd0) ? 3'd1 :
                     (MEM_len_in == 2'd1) ? 3'd2 : 3'd4;
        start_addr = MEM_req_in ? MEM_addr_in : IF_addr_in;
    end

    // Byte k is read while cnt_q == k+1: the RAM answers one cycle after the
    // address was presented.
    always_comb begin
        rdata_nx = rdata_q;
        case (cnt_q)
            3'd1:    rdata_nx[7:0]   = ram_data_in;
            3'd2:    rdata_nx[15:8]  = ram_data_in;
            3'd3:    rdata_nx[23:16] = ram_data_in;
            3'd4:    rdata_nx[31:24] = ram_data_in;
            default: ;
        endcase
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d   = state_q;
        start_mem = 1'b0;
        start_if  = 1'b0;
        if_abort  = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (MEM_req_in) begin
                    start_mem = 1'b1;
                    state_d   = MEM_we_in ? MEM_WR : MEM_RD;
                end else if (IF_req_in) begin
                    start_if = 1'b1;
                    state_d  = IF_RD;
                end else begin
                    state_d = IDLE;
                end
            end
            IF_RD: begin
                // A dropped request or a new PC makes the fetch stale; a
                // waiting MEM request is taken on the same edge.
                if (!IF_req_in || (IF_addr_in != base_q)) begin
                    if_abort = 1'b1;
                    if (MEM_req_in) begin
                        start_mem = 1'b1;
                        state_d   = MEM_we_in ? MEM_WR : MEM_RD;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == nbytes_q) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            MEM_RD: begin
                if (cnt_q == nbytes_q) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            MEM_WR: begin
                if (cnt_q == nbytes_q - 3'd1) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            base_q   <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            nbytes_q <= '0;
            is_mem_q <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            inst_q   <= '0;
            mdata_q  <= '0;
        end else if (start_mem || start_if) begin
            base_q   <= start_addr;
            addr_q   <= start_addr[RAM_ADDR_WIDTH-1:0];
            cnt_q    <= '0;
            nbytes_q <= start_mem ? mem_nbytes : 3'd4;
            is_mem_q <= start_mem;
            wdata_q  <= MEM_data_in;
            rdata_q  <= '0;
        end else if (if_abort) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                IF_RD, MEM_RD: begin
                    cnt_q   <= cnt_q + 3'd1;
                    rdata_q <= rdata_nx;
                    // The last address is held while its byte comes back.
                    if (cnt_q < nbytes_q - 3'd1) begin
                        addr_q <= addr_q + RAM_ADDR_WIDTH'(1);
                    end
                    if (finish) begin
                        if (is_mem_q) begin
                            mdata_q <= rdata_nx;
                        end else begin
                            inst_q <= rdata_nx;
                        end
                    end
                end
                MEM_WR: begin
                    cnt_q   <= cnt_q + 3'd1;
                    wdata_q <= {8'h00, wdata_q[31:8]};
                    if (cnt_q < nbytes_q - 3'd1) begin
                        addr_q <= addr_q + RAM_ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        busy_out     = (state_q == IF_RD) || (state_q == MEM_RD) || (state_q == MEM_WR);
        instE_out    = (state_q == DONE) && !is_mem_q;
        MEM_done_out = (state_q == DONE) && is_mem_q;
        ram_wr_out   = (state_q == MEM_WR);
        ram_data_out = (state_q == MEM_WR) ? wdata_q[7:0] : 8'h00;
        ram_addr_out = addr_q;
        inst_out     = inst_q;
        MEM_data_out = mdata_q;
    end

endmodule
